// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the control pipeline and hazard logic of the
// 5-stage MIPS datapath:
//   - bit positions inside the 8-bit main-decoder control word
//     {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, ALUOp[1:0]}
//   - encodings of the EX-stage operand forwarding selects
//   - the hard-wired zero register specifier
package mips_ctrl_pkg;

  // Control word bit positions
  localparam int RW       = 7;  // RegWrite
  localparam int RD       = 6;  // RegDst (1: rd is destination, 0: rt)
  localparam int AS       = 5;  // ALUSrc
  localparam int BR       = 4;  // Branch
  localparam int MW       = 3;  // MemWrite
  localparam int M2R      = 2;  // MemtoReg (load)
  localparam int ALUOP_HI = 1;
  localparam int ALUOP_LO = 0;

  // EX operand source select
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // register file read
    FWD_WB  = 2'b01,  // result being written back
    FWD_MEM = 2'b10   // ALU result sitting in MEM
  } fwdSelT;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_unit.sv
// hazard_unit
// Purely combinational stall / flush / forwarding decisions.
// Inputs : ID-stage branch flag, taken flag and source specifiers; EX, MEM
//          and WB control bits and destination specifiers.
// Outputs: stall   - hold PC and IF/ID, and bubble the ID/EX register
//          flushD  - clear IF/ID after a taken branch (suppressed on stall)
//          fwdAE/fwdBE - EX operand selects (00 RF, 01 WB, 10 MEM)
//          fwdAD/fwdBD - ID comparator takes the MEM ALU result
module hazard_unit #(
  parameter int REG_W = 5
) (
  input  logic             branchD,
  input  logic             pcSrcD,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic             regWriteE,
  input  logic             memToRegE,
  input  logic [REG_W-1:0] rsE,
  input  logic [REG_W-1:0] rtE,
  input  logic [REG_W-1:0] writeRegE,
  input  logic             regWriteM,
  input  logic             memToRegM,
  input  logic [REG_W-1:0] writeRegM,
  input  logic             regWriteW,
  input  logic [REG_W-1:0] writeRegW,
  output logic             stall,
  output logic             flushD,
  output logic [1:0]       fwdAE,
  output logic [1:0]       fwdBE,
  output logic             fwdAD,
  output logic             fwdBD
);
  import mips_ctrl_pkg::*;

  // A match against $0 is never a dependency: $0 is constant zero.
  function automatic logic regMatch(input logic [REG_W-1:0] src,
                                    input logic [REG_W-1:0] dst);
    return (src != REG_ZERO) && (src == dst);
  endfunction

  // MEM wins over WB because it holds the younger write.
  function automatic logic [1:0] exSelect(input logic [REG_W-1:0] src,
                                          input logic             rwM,
                                          input logic [REG_W-1:0] dstM,
                                          input logic             rwW,
                                          input logic [REG_W-1:0] dstW);
    if (rwM && regMatch(src, dstM))
      return FWD_MEM;
    else if (rwW && regMatch(src, dstW))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  logic lwStall;
  logic branchStall;

  // A load in EX has no data yet; its target is rt for every load.
  assign lwStall = memToRegE & (regMatch(rtE, rsD) | regMatch(rtE, rtD));

  // Branches compare in ID, so an ALU result still in EX or a load still
  // in MEM cannot reach the comparator in time.
  assign branchStall = branchD &
      ((regWriteE & (regMatch(writeRegE, rsD) | regMatch(writeRegE, rtD))) |
       (memToRegM & (regMatch(writeRegM, rsD) | regMatch(writeRegM, rtD))));

  assign stall  = lwStall | branchStall;
  // The branch in ID may be comparing stale operands while stalled, so its
  // taken flag is not trusted until the stall clears.
  assign flushD = pcSrcD & ~stall;

  assign fwdAE = exSelect(rsE, regWriteM, writeRegM, regWriteW, writeRegW);
  assign fwdBE = exSelect(rtE, regWriteM, writeRegM, regWriteW, writeRegW);

  assign fwdAD = regWriteM & regMatch(rsD, writeRegM);
  assign fwdBD = regWriteM & regMatch(rtD, writeRegM);

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard
// Carries the ID control word and register specifiers through the ID/EX,
// EX/MEM and MEM/WB pipeline registers and produces the hazard controls.
// Inputs : clk, reset (synchronous, active-high), ctrl_d, rs_d, rt_d, rd_d,
//          pcsrc_d (branch taken, resolved in ID).
// Outputs: EX  - ctrl_e, rs_e, rt_e, write_reg_e
//          MEM - reg_write_m, mem_write_m, mem_to_reg_m, write_reg_m
//          WB  - reg_write_w, mem_to_reg_w, write_reg_w
//          hazard - stall_f, stall_d, flush_d, fwd_a_e, fwd_b_e,
//                   fwd_a_d, fwd_b_d
// All-zero register contents are a bubble: no register or memory write.
module ctrl_pipe_hazard #(
  parameter int REG_W  = 5,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [REG_W-1:0]  rs_d,
  input  logic [REG_W-1:0]  rt_d,
  input  logic [REG_W-1:0]  rd_d,
  input  logic              pcsrc_d,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [REG_W-1:0]  rs_e,
  output logic [REG_W-1:0]  rt_e,
  output logic [REG_W-1:0]  write_reg_e,
  output logic              reg_write_m,
  output logic              mem_write_m,
  output logic              mem_to_reg_m,
  output logic [REG_W-1:0]  write_reg_m,
  output logic              reg_write_w,
  output logic              mem_to_reg_w,
  output logic [REG_W-1:0]  write_reg_w,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              fwd_a_d,
  output logic              fwd_b_d
);
  import mips_ctrl_pkg::*;

  logic             stall;
  logic             flushE;
  logic [REG_W-1:0] writeRegD;

  assign writeRegD = ctrl_d[RD] ? rd_d : rt_d;
  // The instruction held in ID during a stall must not also enter EX.
  assign flushE    = stall;
  assign stall_f   = stall;
  assign stall_d   = stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_e       <= '0;
      rs_e         <= '0;
      rt_e         <= '0;
      write_reg_e  <= '0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      mem_to_reg_m <= 1'b0;
      write_reg_m  <= '0;
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      write_reg_w  <= '0;
    end else begin
      // ID/EX: the only stage that can take a bubble
      if (flushE) begin
        ctrl_e      <= '0;
        rs_e        <= '0;
        rt_e        <= '0;
        write_reg_e <= '0;
      end else begin
        ctrl_e      <= ctrl_d;
        rs_e        <= rs_d;
        rt_e        <= rt_d;
        write_reg_e <= writeRegD;
      end
      // EX/MEM and MEM/WB always advance; only the bits used downstream move on
      reg_write_m  <= ctrl_e[RW];
      mem_write_m  <= ctrl_e[MW];
      mem_to_reg_m <= ctrl_e[M2R];
      write_reg_m  <= write_reg_e;
      reg_write_w  <= reg_write_m;
      mem_to_reg_w <= mem_to_reg_m;
      write_reg_w  <= write_reg_m;
    end
  end

  hazard_unit #(
    .REG_W(REG_W)
  ) hazardUnit (
    .branchD   (ctrl_d[BR]),
    .pcSrcD    (pcsrc_d),
    .rsD       (rs_d),
    .rtD       (rt_d),
    .regWriteE (ctrl_e[RW]),
    .memToRegE (ctrl_e[M2R]),
    .rsE       (rs_e),
    .rtE       (rt_e),
    .writeRegE (write_reg_e),
    .regWriteM (reg_write_m),
    .memToRegM (mem_to_reg_m),
    .writeRegM (write_reg_m),
    .regWriteW (reg_write_w),
    .writeRegW (write_reg_w),
    .stall     (stall),
    .flushD    (flush_d),
    .fwdAE     (fwd_a_e),
    .fwdBE     (fwd_b_e),
    .fwdAD     (fwd_a_d),
    .fwdBD     (fwd_b_d)
  );

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// tb_ctrl_pipe_hazard
// Directed table of instruction sequences, hand-written multi-cycle corner
// cases, then random instruction streams compared cycle by cycle against an
// instruction-level model of the pipeline.
module tb_ctrl_pipe_hazard;

  localparam logic [7:0] OP_RT  = 8'hC2;  // add/sub: RegWrite, RegDst, ALUOp=10
  localparam logic [7:0] OP_LW  = 8'hA4;  // RegWrite, ALUSrc, MemtoReg
  localparam logic [7:0] OP_SW  = 8'h28;  // ALUSrc, MemWrite
  localparam logic [7:0] OP_BEQ = 8'h11;  // Branch, ALUOp=01
  localparam logic [7:0] OP_NOP = 8'h00;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ctrl_d;
  logic [4:0] rs_d, rt_d, rd_d;
  logic       pcsrc_d;
  logic [7:0] ctrl_e;
  logic [4:0] rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_m, mem_write_m, mem_to_reg_m;
  logic       reg_write_w, mem_to_reg_w;
  logic       stall_f, stall_d, flush_d;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       fwd_a_d, fwd_b_d;

  always #5 clk = ~clk;

  ctrl_pipe_hazard dut (
    .clk          (clk),
    .reset        (reset),
    .ctrl_d       (ctrl_d),
    .rs_d         (rs_d),
    .rt_d         (rt_d),
    .rd_d         (rd_d),
    .pcsrc_d      (pcsrc_d),
    .ctrl_e       (ctrl_e),
    .rs_e         (rs_e),
    .rt_e         (rt_e),
    .write_reg_e  (write_reg_e),
    .reg_write_m  (reg_write_m),
    .mem_write_m  (mem_write_m),
    .mem_to_reg_m (mem_to_reg_m),
    .write_reg_m  (write_reg_m),
    .reg_write_w  (reg_write_w),
    .mem_to_reg_w (mem_to_reg_w),
    .write_reg_w  (write_reg_w),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .fwd_a_e      (fwd_a_e),
    .fwd_b_e      (fwd_b_e),
    .fwd_a_d      (fwd_a_d),
    .fwd_b_d      (fwd_b_d)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyId(input logic [7:0] c, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic p);
    ctrl_d  = c;
    rs_d    = s;
    rt_d    = t;
    rd_d    = d;
    pcsrc_d = p;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] ctrl;
    logic [4:0] rs, rt, rd;
    logic       pcsrc;
    logic [7:0] eCtrlE;
    logic [4:0] eWrE;
    logic       eStall, eFlushD;
    logic [1:0] eFwdAE, eFwdBE;
    logic       eFwdAD, eFwdBD;
  } vecT;

  localparam int NV = 20;
  vecT vecs [NV];

  // ---------------- reference model ----------------
  // One record per instruction; index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct packed {
    logic [7:0] ctrl;
    logic [4:0] rs, rt, dst;
  } instrT;

  typedef struct packed {
    logic [7:0] ctrlE;
    logic [4:0] rsE, rtE, wrE;
    logic       rwM, mwM, m2rM;
    logic [4:0] wrM;
    logic       rwW, m2rW;
    logic [4:0] wrW;
    logic       stall, flushD;
    logic [1:0] fwdAE, fwdBE;
    logic       fwdAD, fwdBD;
  } expT;

  instrT pipe [3];

  function automatic logic writesReg(input instrT i, input logic [4:0] r);
    return i.ctrl[7] && (r != 5'd0) && (i.dst == r);
  endfunction

  function automatic logic loadsReg(input instrT i, input logic [4:0] r);
    return i.ctrl[2] && (r != 5'd0) && (i.dst == r);
  endfunction

  function automatic logic [1:0] srcSel(input logic [4:0] r);
    if (writesReg(pipe[1], r)) return 2'b10;
    if (writesReg(pipe[2], r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic modelStall();
    logic lw, br;
    lw = pipe[0].ctrl[2] && (pipe[0].rt != 5'd0) && (pipe[0].rt == rs_d || pipe[0].rt == rt_d);
    br = ctrl_d[4] && (writesReg(pipe[0], rs_d) || writesReg(pipe[0], rt_d) ||
                       loadsReg(pipe[1], rs_d) || loadsReg(pipe[1], rt_d));
    return lw || br;
  endfunction

  function automatic expT modelExpect();
    expT e;
    e.ctrlE  = pipe[0].ctrl;
    e.rsE    = pipe[0].rs;
    e.rtE    = pipe[0].rt;
    e.wrE    = pipe[0].dst;
    e.rwM    = pipe[1].ctrl[7];
    e.mwM    = pipe[1].ctrl[3];
    e.m2rM   = pipe[1].ctrl[2];
    e.wrM    = pipe[1].dst;
    e.rwW    = pipe[2].ctrl[7];
    e.m2rW   = pipe[2].ctrl[2];
    e.wrW    = pipe[2].dst;
    e.stall  = modelStall();
    e.flushD = pcsrc_d && !e.stall;
    e.fwdAE  = srcSel(pipe[0].rs);
    e.fwdBE  = srcSel(pipe[0].rt);
    e.fwdAD  = writesReg(pipe[1], rs_d);
    e.fwdBD  = writesReg(pipe[1], rt_d);
    return e;
  endfunction

  task automatic modelClock();
    instrT nxt;
    logic  st;
    st = modelStall();
    nxt.ctrl = ctrl_d;
    nxt.rs   = rs_d;
    nxt.rt   = rt_d;
    nxt.dst  = ctrl_d[6] ? rd_d : rt_d;
    if (reset) begin
      for (int k = 0; k < 3; k++) pipe[k] = '0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = st ? instrT'('0) : nxt;
    end
  endtask

  task automatic compareAll(input string tag, input expT e);
    check({tag, "_ctrl_e"},       32'(ctrl_e),       32'(e.ctrlE));
    check({tag, "_rs_e"},         32'(rs_e),         32'(e.rsE));
    check({tag, "_rt_e"},         32'(rt_e),         32'(e.rtE));
    check({tag, "_write_reg_e"},  32'(write_reg_e),  32'(e.wrE));
    check({tag, "_reg_write_m"},  32'(reg_write_m),  32'(e.rwM));
    check({tag, "_mem_write_m"},  32'(mem_write_m),  32'(e.mwM));
    check({tag, "_mem_to_reg_m"}, 32'(mem_to_reg_m), 32'(e.m2rM));
    check({tag, "_write_reg_m"},  32'(write_reg_m),  32'(e.wrM));
    check({tag, "_reg_write_w"},  32'(reg_write_w),  32'(e.rwW));
    check({tag, "_mem_to_reg_w"}, 32'(mem_to_reg_w), 32'(e.m2rW));
    check({tag, "_write_reg_w"},  32'(write_reg_w),  32'(e.wrW));
    check({tag, "_stall_f"},      32'(stall_f),      32'(e.stall));
    check({tag, "_stall_d"},      32'(stall_d),      32'(e.stall));
    check({tag, "_flush_d"},      32'(flush_d),      32'(e.flushD));
    check({tag, "_fwd_a_e"},      32'(fwd_a_e),      32'(e.fwdAE));
    check({tag, "_fwd_b_e"},      32'(fwd_b_e),      32'(e.fwdBE));
    check({tag, "_fwd_a_d"},      32'(fwd_a_d),      32'(e.fwdAD));
    check({tag, "_fwd_b_d"},      32'(fwd_b_d),      32'(e.fwdBD));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    expT  e;
    logic [7:0] kinds [6];

    // ctrl, rs, rt, rd, pcsrc | ctrl_e, write_reg_e, stall, flush_d, fwdAE, fwdBE, fwdAD, fwdBD
    vecs[0]  = '{OP_RT,  5'd1, 5'd2, 5'd3, 1'b0, OP_NOP, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0}; // add $3,$1,$2
    vecs[1]  = '{OP_RT,  5'd3, 5'd5, 5'd4, 1'b0, OP_RT,  5'd3, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0}; // sub $4,$3,$5
    vecs[2]  = '{OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, OP_RT,  5'd4, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0}; // sub in EX: MEM fwd
    vecs[3]  = '{OP_RT,  5'd1, 5'd2, 5'd6, 1'b0, OP_NOP, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0}; // add $6,$1,$2
    vecs[4]  = '{OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, OP_RT,  5'd6, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{OP_RT,  5'd6, 5'd6, 5'd7, 1'b0, OP_NOP, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1}; // sub $7,$6,$6
    vecs[6]  = '{OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, OP_RT,  5'd7, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0}; // WB fwd both
    vecs[7]  = '{OP_LW,  5'd1, 5'd2, 5'd0, 1'b0, OP_NOP, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0}; // lw $2,0($1)
    vecs[8]  = '{OP_RT,  5'd2, 5'd3, 5'd4, 1'b0, OP_LW,  5'd2, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0}; // add $4,$2,$3 stalls
    vecs[9]  = '{OP_RT,  5'd2, 5'd3, 5'd4, 1'b0, OP_NOP, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0}; // bubble in EX
    vecs[10] = '{OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, OP_RT,  5'd4, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0}; // add gets WB fwd
    vecs[11] = '{OP_RT,  5'd5, 5'd6, 5'd1, 1'b0, OP_NOP, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0}; // add $1,$5,$6
    vecs[12] = '{OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b1, OP_RT,  5'd1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0}; // beq stalls, no flush
    vecs[13] = '{OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b1, OP_NOP, 5'd0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0}; // beq fwd, flush
    vecs[14] = '{OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, OP_BEQ, 5'd2, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0};
    vecs[15] = '{OP_RT,  5'd1, 5'd2, 5'd0, 1'b0, OP_NOP, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0}; // add $0,$1,$2
    vecs[16] = '{OP_RT,  5'd0, 5'd0, 5'd5, 1'b0, OP_RT,  5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0}; // add $5,$0,$0
    vecs[17] = '{OP_BEQ, 5'd0, 5'd0, 5'd0, 1'b1, OP_RT,  5'd5, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0}; // beq $0,$0 taken
    vecs[18] = '{OP_LW,  5'd3, 5'd0, 5'd0, 1'b0, OP_BEQ, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0}; // lw $0,0($3)
    vecs[19] = '{OP_RT,  5'd0, 5'd0, 5'd1, 1'b0, OP_LW,  5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0}; // load of $0: no stall

    // ---------------- reset state ----------------
    reset = 1'b1;
    applyId(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    compareAll("reset", expT'('0));
    $display("reset state checked");
    @(posedge clk); #1;
    reset = 1'b0;

    // ---------------- directed table ----------------
    for (int i = 0; i < NV; i++) begin
      applyId(vecs[i].ctrl, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].pcsrc);
      @(negedge clk);
      check($sformatf("v%0d_ctrl_e", i),      32'(ctrl_e),      32'(vecs[i].eCtrlE));
      check($sformatf("v%0d_write_reg_e", i), 32'(write_reg_e), 32'(vecs[i].eWrE));
      check($sformatf("v%0d_stall_f", i),     32'(stall_f),     32'(vecs[i].eStall));
      check($sformatf("v%0d_stall_d", i),     32'(stall_d),     32'(vecs[i].eStall));
      check($sformatf("v%0d_flush_d", i),     32'(flush_d),     32'(vecs[i].eFlushD));
      check($sformatf("v%0d_fwd_a_e", i),     32'(fwd_a_e),     32'(vecs[i].eFwdAE));
      check($sformatf("v%0d_fwd_b_e", i),     32'(fwd_b_e),     32'(vecs[i].eFwdBE));
      check($sformatf("v%0d_fwd_a_d", i),     32'(fwd_a_d),     32'(vecs[i].eFwdAD));
      check($sformatf("v%0d_fwd_b_d", i),     32'(fwd_b_d),     32'(vecs[i].eFwdBD));
      $display("vec %0d: ctrl_d=%h rs=%0d rt=%0d -> ctrl_e=%h stall=%b flush_d=%b fwdE=%0d/%0d fwdD=%b/%b",
               i, ctrl_d, rs_d, rt_d, ctrl_e, stall_d, flush_d, fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d);
      @(posedge clk); #1;
    end

    // ---------------- lw $1 then taken beq $1,$2: two stall cycles ----------------
    applyId(OP_LW, 5'd3, 5'd1, 5'd0, 1'b0);
    @(posedge clk); #1;
    applyId(OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b1);
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (!stall_d) break;
      check("lwbeq_flush_in_stall", 32'(flush_d), 32'd0);
      n++;
      @(posedge clk); #1;
    end
    check("lwbeq_stall_cycles", 32'(n), 32'd2);
    check("lwbeq_flush_after", 32'(flush_d), 32'd1);
    check("lwbeq_fwd_a_d", 32'(fwd_a_d), 32'd0);
    $display("lw/beq: stall cycles=%0d flush_d=%b", n, flush_d);
    @(posedge clk); #1;

    // ---------------- reset with a load in flight ----------------
    applyId(OP_LW, 5'd1, 5'd2, 5'd0, 1'b0);
    @(posedge clk); #1;
    applyId(OP_RT, 5'd2, 5'd3, 5'd4, 1'b0);
    @(negedge clk);
    check("midrst_pre_stall", 32'(stall_d), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ctrl_e",      32'(ctrl_e),      32'd0);
    check("midrst_reg_write_m", 32'(reg_write_m), 32'd0);
    check("midrst_reg_write_w", 32'(reg_write_w), 32'd0);
    check("midrst_stall_f",     32'(stall_f),     32'd0);
    check("midrst_stall_d",     32'(stall_d),     32'd0);
    check("midrst_flush_d",     32'(flush_d),     32'd0);
    check("midrst_fwd_a_e",     32'(fwd_a_e),     32'd0);
    check("midrst_fwd_b_e",     32'(fwd_b_e),     32'd0);
    check("midrst_fwd_a_d",     32'(fwd_a_d),     32'd0);
    check("midrst_fwd_b_d",     32'(fwd_b_d),     32'd0);
    $display("mid-stream reset: ctrl_e=%h rw_m=%b rw_w=%b stall=%b", ctrl_e, reg_write_m, reg_write_w, stall_d);
    @(posedge clk); #1;

    // ---------------- random streams vs model ----------------
    kinds[0] = OP_RT; kinds[1] = OP_LW; kinds[2] = OP_SW;
    kinds[3] = OP_BEQ; kinds[4] = OP_NOP; kinds[5] = OP_RT;
    reset = 1'b1;
    applyId(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    modelClock();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [7:0] c;
      c = ($urandom_range(0, 7) == 0) ? 8'($urandom) : kinds[$urandom_range(0, 5)];
      applyId(c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      reset = ($urandom_range(0, 39) == 0);
      e = modelExpect();
      @(negedge clk);
      compareAll($sformatf("rnd%0d", cyc), e);
      if (cyc % 500 == 0)
        $display("rnd %0d: ctrl_d=%h rs=%0d rt=%0d stall=%b fwdE=%0d/%0d", cyc, ctrl_d, rs_d, rt_d,
                 stall_d, fwd_a_e, fwd_b_e);
      @(posedge clk);
      modelClock();
      #1;
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
